// File: rtl/debug_step_controller.sv
`default_nettype none
// ============================================================================
// Module   : debug_step_controller
// Brief    : UART-command driven run/step/reset controller for the PC and
//            pipeline; reports the PC over the UART whenever execution stops.
// Revision : 1.0 - initial release
// ============================================================================
module debug_step_controller #(
    parameter int              ADDR_WIDTH   = 8,
    parameter logic [7:0]      HALT_ADDR    = 8'hFF,
    parameter int              RESET_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic [ADDR_WIDTH-1:0] pc_addr,
    input  logic                  tx_busy,
    output logic                  enableDebug,
    output logic                  resetDebug,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    output logic                  running
);

    localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [7:0] C_CMD_RUN   = 8'h63;
    localparam logic [7:0] C_CMD_STEP  = 8'h73;
    localparam logic [7:0] C_CMD_RESET = 8'h72;
    localparam logic [7:0] C_CMD_PRINT = 8'h70;
    localparam logic [7:0] C_CMD_HALT  = 8'h68;

    localparam logic [ADDR_WIDTH-1:0] C_HALT_PC   = HALT_ADDR[ADDR_WIDTH-1:0];
    localparam logic [CNT_W-1:0]      C_RST_LAST  = CNT_W'(RESET_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_STEP   = 3'd2;
    localparam logic [2:0] S_WAIT1  = 3'd3;
    localparam logic [2:0] S_RST    = 3'd4;
    localparam logic [2:0] S_SEND   = 3'd5;
    localparam logic [2:0] S_TXWAIT = 3'd6;

    logic [2:0]       state_q,     state_d;
    logic [CNT_W-1:0] rst_cnt_q,   rst_cnt_d;
    logic             seen_busy_q, seen_busy_d;
    logic             en_q,        en_d;
    logic             rstdbg_q,    rstdbg_d;
    logic [7:0]       tx_data_q,   tx_data_d;
    logic             tx_start_q,  tx_start_d;
    logic [7:0]       pc_ext;

    always_comb begin
        pc_ext                 = '0;
        pc_ext[ADDR_WIDTH-1:0] = pc_addr;
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rst_cnt_q   <= '0;
            seen_busy_q <= 1'b0;
            en_q        <= 1'b0;
            rstdbg_q    <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            seen_busy_q <= seen_busy_d;
            en_q        <= en_d;
            rstdbg_q    <= rstdbg_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        C_CMD_RUN:   state_d = S_RUN;
                        C_CMD_STEP:  state_d = S_STEP;
                        C_CMD_RESET: state_d = S_RST;
                        C_CMD_PRINT: state_d = S_SEND;
                        default:     state_d = S_IDLE;
                    endcase
                end
            end
            S_RUN: begin
                if ((pc_addr == C_HALT_PC) || (rx_valid && (rx_data == C_CMD_HALT)))
                    state_d = S_SEND;
            end
            S_STEP:  state_d = S_WAIT1;
            S_WAIT1: state_d = S_SEND;
            S_RST: begin
                if (rst_cnt_q == C_RST_LAST)
                    state_d = S_IDLE;
            end
            // The pulse was issued on entry (or when busy dropped); move on once it is out
            S_SEND: begin
                if (tx_start_q)
                    state_d = S_TXWAIT;
            end
            S_TXWAIT: begin
                if (seen_busy_q && !tx_busy)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with it
    always_comb begin
        en_d        = (state_d == S_RUN) || (state_d == S_STEP);
        rstdbg_d    = (state_d == S_RST);
        tx_start_d  = (state_d == S_SEND) && !tx_busy && !tx_start_q;
        tx_data_d   = tx_start_d ? pc_ext : tx_data_q;
        rst_cnt_d   = ((state_q == S_RST) && (state_d == S_RST)) ? rst_cnt_q + 1'b1 : '0;
        seen_busy_d = (state_q == S_TXWAIT) ? (seen_busy_q | tx_busy) : 1'b0;
    end

    assign enableDebug = en_q;
    assign resetDebug  = rstdbg_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign running     = (state_q == S_RUN) || (state_q == S_STEP);

endmodule
`default_nettype wire

// File: tb/tb_debug_step_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_step_controller
// Brief    : Directed self-checking bench with a counting PC and UART-busy model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_step_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] pc_addr = 8'h00;
    logic       tx_busy;
    logic       enableDebug;
    logic       resetDebug;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       running;

    logic       ld = 1'b0;
    logic [7:0] ld_val = 8'h00;
    logic       force_busy = 1'b0;
    logic [2:0] bcnt = 3'd0;

    int errors = 0;
    int checks = 0;

    debug_step_controller #(
        .ADDR_WIDTH   (8),
        .HALT_ADDR    (8'h0A),
        .RESET_CYCLES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .pc_addr     (pc_addr),
        .tx_busy     (tx_busy),
        .enableDebug (enableDebug),
        .resetDebug  (resetDebug),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .running     (running)
    );

    always #5 clk = ~clk;

    // Program counter: synchronous clear beats advance; bench can preload it
    always @(posedge clk) begin
        if (ld)               pc_addr <= ld_val;
        else if (resetDebug)  pc_addr <= 8'h00;
        else if (enableDebug) pc_addr <= pc_addr + 8'h01;
    end

    // Transmitter stays busy three cycles after each start
    always @(posedge clk) begin
        if (tx_start)          bcnt <= 3'd3;
        else if (bcnt != 3'd0) bcnt <= bcnt - 3'd1;
    end
    assign tx_busy = force_busy | (bcnt != 3'd0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic load_pc(input logic [7:0] v);
        @(negedge clk);
        ld     = 1'b1;
        ld_val = v;
        @(negedge clk);
        ld     = 1'b0;
    endtask

    initial begin
        int         n;
        int         txs;
        logic [7:0] p0;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_en",      enableDebug, 0);
        chk("rst_rdbg",    resetDebug,  0);
        chk("rst_txdata",  tx_data,     0);
        chk("rst_txstart", tx_start,    0);
        chk("rst_running", running,     0);

        // Single step from PC 5
        load_pc(8'h05);
        send(8'h73);
        chk("step_en_n1",   enableDebug, 1);
        chk("step_run_n1",  running,     1);
        @(negedge clk);
        chk("step_en_n2",   enableDebug, 0);
        chk("step_txs_n2",  tx_start,    0);
        @(negedge clk);
        chk("step_txs_n3",  tx_start,    1);
        chk("step_txd_n3",  tx_data,     8'h06);
        @(negedge clk);
        chk("step_txs_n4",  tx_start,    0);
        repeat (10) @(negedge clk);

        // Run from 0 until the halt address 0x0A
        load_pc(8'h00);
        send(8'h63);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!enableDebug) break;
            n++;
            @(negedge clk);
        end
        chk("run_en_cycles", n,        11);
        chk("run_txs",       tx_start, 1);
        chk("run_txd",       tx_data,  8'h0A);
        chk("run_running",   running,  0);
        repeat (10) @(negedge clk);

        // Halt address already present: one enable cycle only
        load_pc(8'h0A);
        send(8'h63);
        chk("hpre_en_n1",  enableDebug, 1);
        @(negedge clk);
        chk("hpre_en_n2",  enableDebug, 0);
        chk("hpre_txs",    tx_start,    1);
        chk("hpre_txd",    tx_data,     8'h0A);
        repeat (10) @(negedge clk);

        // Run, then 'h' while PC is 3
        load_pc(8'h00);
        send(8'h63);
        repeat (3) @(negedge clk);
        rx_data  = 8'h68;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("halt_en",  enableDebug, 0);
        chk("halt_txs", tx_start,    1);
        chk("halt_txd", tx_data,     8'h03);
        repeat (10) @(negedge clk);

        // Reset command: two cycles of resetDebug, nothing transmitted
        send(8'h72);
        txs = 0;
        chk("rcmd_rdbg_n1", resetDebug,  1);
        chk("rcmd_en_n1",   enableDebug, 0);
        txs += int'(tx_start);
        @(negedge clk);
        chk("rcmd_rdbg_n2", resetDebug,  1);
        chk("rcmd_en_n2",   enableDebug, 0);
        txs += int'(tx_start);
        @(negedge clk);
        chk("rcmd_rdbg_n3", resetDebug,  0);
        for (int i = 0; i < 6; i++) begin
            txs += int'(tx_start);
            @(negedge clk);
        end
        chk("rcmd_no_tx", txs, 0);
        chk("rcmd_pc",    pc_addr, 8'h00);

        // Print while the transmitter is busy for 20 cycles
        force_busy = 1'b1;
        send(8'h70);
        txs = 0;
        for (int i = 0; i < 19; i++) begin
            txs += int'(tx_start);
            @(negedge clk);
        end
        force_busy = 1'b0;
        txs += int'(tx_start);
        chk("print_hold_tx", txs, 0);
        @(negedge clk);
        chk("print_txs", tx_start, 1);
        chk("print_txd", tx_data,  8'h00);
        rx_data  = 8'h73;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            n += int'(enableDebug);
            @(negedge clk);
        end
        chk("txwait_step_dropped", n, 0);
        repeat (6) @(negedge clk);

        // Asynchronous reset during RUN
        load_pc(8'h20);
        send(8'h63);
        @(negedge clk);
        chk("arst_pre_en", enableDebug, 1);
        #1 reset = 1'b1;
        #1;
        chk("arst_en",      enableDebug, 0);
        chk("arst_running", running,     0);
        chk("arst_txs",     tx_start,    0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        p0 = pc_addr;
        send(8'h73);
        chk("arst_step_en1", enableDebug, 1);
        @(negedge clk);
        chk("arst_step_en2", enableDebug, 0);
        @(negedge clk);
        chk("arst_step_txs", tx_start, 1);
        chk("arst_step_txd", tx_data,  p0 + 8'h01);
        repeat (8) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
